// File: rtl/serial_sub_ctrl_pkg.sv
// Shared constants for the bit-serial subtractor sequencer.
package serial_sub_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // The legacy numeric encodings are kept so existing state decodes still line up.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated or propagated from the borrow-in.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one shared full_sub cell.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_d_q, sh_d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             zero_q, zero_d;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] sh_d_next;

  full_sub u_cell (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .bin  (brw_q),
    .d    (cell_diff),
    .bout (cell_bout)
  );

  // Next-state and datapath: load on accept, shift one bit per SHIFT cycle.
  always_comb begin
    state_d      = state_q;
    sh_a_d       = sh_a_q;
    sh_b_d       = sh_b_q;
    sh_d_d       = sh_d_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    sh_d_next    = {cell_diff, sh_d_q[WIDTH-1:1]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          brw_d   = bin_init;
          cnt_d   = '0;
          sh_d_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          sh_d_d = sh_d_next;
          sh_a_d = sh_a_q >> 1;
          sh_b_d = sh_b_q >> 1;
          brw_d  = cell_bout;
          cnt_d  = cnt_q + 1'b1;
          // Results are taken from the final-shift values directly so they land on the SHIFT->DONE edge.
          if (cnt_q == CW'(WIDTH - 1)) begin
            diff_d       = sh_d_next;
            borrow_out_d = cell_bout;
            zero_d       = (sh_d_next == '0);
            state_d      = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      sh_d_q       <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_a_q       <= sh_a_d;
      sh_b_q       <= sh_b_d;
      sh_d_q       <= sh_d_d;
      cnt_q        <= cnt_d;
      brw_q        <= brw_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  // Output decode.
  always_comb begin
    busy       = (state_q == S_SHIFT);
    done       = (state_q == S_DONE);
    diff       = diff_q;
    borrow_out = borrow_out_q;
    zero       = zero_q;
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomised and directed bench for serial_sub_ctrl against an arithmetic model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin_init = 1'b0;
  logic         busy, done, borrow_out, zero;
  logic [W-1:0] diff;

  int n_cmp = 0;
  int n_bad = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .bin_init   (bin_init),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation is "bits left to process", then a done cycle.
  int           m_rem = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_diff = '0, m_pend_diff = '0;
  bit           m_bout = 1'b0, m_pend_bout = 1'b0;
  bit           m_zero = 1'b0, m_pend_zero = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_done = 0; m_diff = '0; m_bout = 0; m_zero = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_rem > 0) begin
      if (abort) m_rem = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1;
          m_diff = m_pend_diff; m_bout = m_pend_bout; m_zero = m_pend_zero;
        end
      end
    end else if (start) begin
      int full;
      full        = int'(a) - int'(b) - int'(bin_init);
      m_pend_diff = W'(full & ((1 << W) - 1));
      m_pend_bout = (full < 0);
      m_pend_zero = (m_pend_diff == 0);
      m_rem       = W;
    end
  end

  bit chk_en = 1'b0;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("borrow_out", 32'(borrow_out), 32'(m_bout));
      chk("zero", 32'(zero), 32'(m_zero));
    end
  end

  // One operation with optional ignored-start injection and abort, observed for 12 cycles.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                    input int start_at, input int abort_at,
                    output int first_done, output int ndone, output int nbusy, output int busy_after_abort);
    first_done = -1; ndone = 0; nbusy = 0; busy_after_abort = -1;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; a = ta; b = tb; bin_init = tbin;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      if (k == abort_at + 1) busy_after_abort = int'(busy);
      start    = (k == start_at);
      abort    = (k == abort_at);
      a        = (k == start_at) ? 8'h01 : W'($urandom);
      b        = (k == start_at) ? 8'h01 : W'($urandom);
      bin_init = 1'($urandom);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          input logic [W-1:0] ed, input logic eb, input logic ez, input int start_at);
    int fd, nd, nb, ba;
    op(ta, tb, tbin, start_at, 0, fd, nd, nb, ba);
    chk({nm, "_done_cycle"}, 32'(fd), 32'(W + 1));
    chk({nm, "_done_count"}, 32'(nd), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(W));
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
    chk({nm, "_zero"}, 32'(zero), 32'(ez));
  endtask

  initial begin
    int fd, nd, nb, ba;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_borrow", 32'(borrow_out), 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    directed("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 3);
    directed("underflow", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 0);

    op(8'h80, 8'h01, 1'b0, 0, 4, fd, nd, nb, ba);
    chk("abort_done_count", 32'(nd), 32'd0);
    chk("abort_busy_after", 32'(ba), 32'd0);
    chk("abort_diff_held", 32'(diff), 32'hF0);
    chk("abort_borrow_held", 32'(borrow_out), 32'd1);

    directed("borrow_in", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    directed("equal", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; a = 8'h77; b = 8'h11; bin_init = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow_out), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    directed("post_reset", 8'h33, 8'h11, 1'b1, 8'h21, 1'b0, 1'b0, 0);

    // Random traffic, including start noise and occasional aborts.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 99) < 30);
      abort    = ($urandom_range(0, 99) < 3);
      a        = W'($urandom);
      b        = ($urandom_range(0, 9) == 0) ? a : W'($urandom);
      bin_init = 1'($urandom);
    end
    start = 1'b0; abort = 1'b0;
    repeat (W + 3) @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Sequencer that performs a WIDTH-bit unsigned subtraction a - b - bin_init bit-serially, LSB first.
- Uses one instance of the team's one-bit full subtractor cell, with a registered borrow chain, one bit per clock.
- Provides a start/done handshake so a higher-level datapath can share one subtractor cell across multi-bit operations.
- Trades latency (WIDTH+1 cycles) for area; intended for the small-ALU practicals that follow.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk, input, 1, single system clock; rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a new operation; sampled only in IDLE.
- abort, input, 1, synchronous cancel of a running operation.
- a, input, WIDTH, minuend; captured on the start-accept edge.
- b, input, WIDTH, subtrahend; captured on the start-accept edge.
- bin_init, input, 1, initial borrow-in; captured on the start-accept edge.
- busy, output, 1, high while state is SHIFT.
- done, output, 1, one-cycle pulse when a result becomes valid.
- diff, output, WIDTH, registered difference; held until the next done.
- borrow_out, output, 1, final borrow (1 ⇔ a < b + bin_init, unsigned).
- zero, output, 1, diff == 0; registered with diff.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, borrow_out, zero=0; diff=0; internal shift registers, counter and borrow register cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load sh_a=a, sh_b=b, brw=bin_init, cnt=0, sh_d=0; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, each cycle:
  - Cell inputs: sh_a[0], sh_b[0], brw.
  - sh_d <= {cell_diff, sh_d[WIDTH-1:1]}.
  - sh_a and sh_b shift right by 1.
  - brw <= cell_bout; cnt <= cnt+1.
  - When cnt==WIDTH-1, the final shift occurs and the next state is DONE.
- DONE (exactly one cycle):
  - done=1.
  - diff, borrow_out and zero were registered on the SHIFT→DONE edge, from the final shift/borrow values.
  - Next state is IDLE unconditionally.
- Latency: start sampled on edge N → busy high for cycles N+1..N+WIDTH → done high in cycle N+WIDTH+1. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored; it is not queued.
- Operand inputs are don't-care except on the accept edge. Changing them mid-operation has no effect.
- abort=1 in SHIFT → IDLE next edge; no done pulse; diff, borrow_out and zero keep their previous values.
- abort in IDLE or DONE is ignored. abort has priority over the final-bit transition.
- Simultaneous start and abort in IDLE: start wins.
- Result outputs change only on the SHIFT→DONE edge (or reset); they are stable whenever done=0.
- Arithmetic: diff = (a - b - bin_init) mod 2^WIDTH; borrow_out = 1 iff {1'b0,a} < {1'b0,b} + bin_init.
- Reset asserted mid-operation aborts immediately to reset values; no done pulse follows.

Decomposition:
- Shared package holds state encoding localparams (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2).
- Default WIDTH constant also lives in the package.
- One sub-module: the existing one-bit full subtractor cell full_sub, instantiated once, purely combinational.
- Registers and FSM stay in serial_sub_ctrl.

Test Plan (WIDTH=8):
- Basic: a=0x5A, b=0x3C, bin_init=0, start pulse → busy for 8 cycles; done in cycle 9 with diff=0x1E, borrow_out=0, zero=0.
- Underflow: a=0x10, b=0x20, bin_init=0 → diff=0xF0, borrow_out=1, zero=0.
- Borrow-in and equal operands:
  - a=0x00, b=0x00, bin_init=1 → diff=0xFF, borrow_out=1.
  - a=0xFF, b=0xFF, bin_init=0 → diff=0x00, zero=1, borrow_out=0.
- Ignored start: during the 0x5A-0x3C run, pulse start with a=0x01, b=0x01 at cycle 3 → result still 0x1E; exactly one done.
- Abort: after 0xF0 result, start a=0x80, b=0x01, assert abort at cycle 4 → no done; diff stays 0xF0; busy low the next cycle.
- Reset mid-operation: drop rst_n at cycle 5 of a run → all outputs 0 immediately; after release, a new start yields a correct result.
